snax_alu_csr_manager: RTL and testbench
=======================================

// Module: snax_alu_csr_manager
// PURPOSE
// - Initiator side of the accelerator CSR handshake. Sits between the core's CSR request port and the accelerator CSR block.
// - Stages RW config words and serves reads of staged and RO registers.
// - On a launch write, snapshots the staged words and presents them on csr_reg_set_o with a valid/ready handshake.
// - Staging for the next job may continue while a launch is pending.
// PARAMETERS
// RegRWCount    3   number of RW config registers (word addr 0..RegRWCount-1)
// RegROCount    2   number of RO status registers (addr RegRWCount..RegRWCount+RegROCount-1)
// RegDataWidth  32  CSR data width
// RegAddrWidth  32  CSR word-address width
// PORTS
// clk_i                input   1                        clock
// rst_ni               input   1                        asynchronous active-low reset
// csr_req_addr_i       input   RegAddrWidth             word address
// csr_req_data_i       input   RegDataWidth             write data
// csr_req_write_i      input   1                        1=write, 0=read
// csr_req_valid_i      input   1                        request valid
// csr_req_ready_o      output  1                        request accepted when valid&ready
// csr_rsp_data_o       output  RegDataWidth             read data
// csr_rsp_valid_o      output  1                        read response valid
// csr_rsp_ready_i      input   1                        read response consumed
// csr_reg_set_o        output  RegRWCount*RegDataWidth  launched config snapshot, packed [RegRWCount-1:0][RegDataWidth-1:0]
// csr_reg_set_valid_o  output  1                        snapshot valid
// csr_reg_set_ready_i  input   1                        accelerator accepts snapshot
// csr_reg_ro_set_i     input   RegROCount*RegDataWidth  RO values from accelerator, same packing
// BEHAVIOUR
// - Address map:
//   - LaunchAddr = RegRWCount+RegROCount: write any value to launch; reads return 0.
//   - StatusAddr = LaunchAddr+1: RO; bit0 = launch pending, other bits 0.
//   - Other addresses: writes are dropped; reads return 0.
// - Reset: all staged regs, snapshot regs, csr_reg_set_valid_o, csr_rsp_valid_o, csr_rsp_data_o = 0. State = IDLE.
//   Reset mid-launch drops valid immediately and discards the snapshot.
// - Writes:
//   - Accepted on valid&ready. A staged register updates on the next clk edge. No response is generated.
//   - Writes to RO/Status addresses are dropped.
// - Reads:
//   - Accepted on valid&ready. Response is registered: csr_rsp_valid_o rises the cycle after acceptance.
//   - Response data is sampled at acceptance. Staged regs read their current (staged) value, not the snapshot.
//   - csr_rsp_valid_o holds, with stable data, until csr_rsp_ready_i.
//   - At most one read outstanding.
// - csr_req_ready_o = !(rsp_valid & !csr_rsp_ready_i) & !(launch write & state==LAUNCH).
//   - The ready term is combinational on csr_rsp_ready_i, so a read can be accepted back-to-back in the same cycle its predecessor's response is consumed.
// - Launch FSM:
//   - IDLE: accepted launch write -> copy all staged regs to snapshot, go to LAUNCH.
//   - LAUNCH: csr_reg_set_valid_o=1 and csr_reg_set_o=snapshot, both stable.
//     - On csr_reg_set_ready_i -> IDLE; valid drops next cycle.
//   - A launch write arriving in LAUNCH is stalled (ready=0), including in the cycle the handshake completes.
//     It is accepted in the following IDLE cycle and relaunches with the then-current staged values.
//   - Staging writes during LAUNCH are accepted and do not alter the snapshot.
// - Latency: launch accept -> csr_reg_set_valid_o high next cycle.
//   Minimum 2 cycles between consecutive launch handshakes.
// - Addresses compare on the full RegAddrWidth; no aliasing.
// STRUCTURE
// - Shared package snax_csr_mgr_pkg:
//   - launch/status address functions of RegRWCount/RegROCount
//   - launch FSM state enum {IDLE, LAUNCH}
//   - STATUS_PENDING_BIT = 0
// - Single flat module; no sub-module (read mux + two small FSMs).
// TESTING
// - Reset values:
//   - Assert rst_ni=0 mid-LAUNCH -> csr_reg_set_valid_o=0 immediately.
//   - After release, read addr 0 -> 0 and status -> 0.
// - Stage and launch:
//   - Write addr0=0x11, addr1=0x22, addr2=0x3, then launch (addr5) with ready held 0 for 3 cycles.
//   - Required: valid held, csr_reg_set_o={0x3,0x22,0x11} stable, status read bit0=1.
//   - Ready=1 -> valid low next cycle.
// - Stage during launch:
//   - While LAUNCH, write addr0=0xAA -> snapshot word0 stays 0x11; read addr0 -> 0xAA.
//   - Second launch write stalls (csr_req_ready_o=0) until the handshake completes, then csr_reg_set_o word0=0xAA.
// - RO readback:
//   - Drive csr_reg_ro_set_i={0xBEEF,0xCAFE}.
//   - Read addr3 -> 0xCAFE, addr4 -> 0xBEEF, each one cycle after accept.
// - Response backpressure:
//   - Read addr1 with csr_rsp_ready_i=0 for 4 cycles -> rsp held at 0x22, csr_req_ready_o=0.
//   - Back-to-back read accepted in the cycle ready=1.
// - Out-of-range:
//   - Write addr 9=0x55 -> no register changes.
//   - Read addr 9 -> 0.
//   - Write status addr -> ignored.

Source files
------------

// File: rtl/snax_csr_mgr_pkg.sv
// Shared definitions for the accelerator CSR manager: address map helpers and launch FSM states.
package snax_csr_mgr_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LAUNCH = 1'b1
  } launch_state_e;

  localparam int STATUS_PENDING_BIT = 0;

  // Launch sits just past the RW and RO windows; status follows it.
  function automatic int launch_addr(input int rw_count, input int ro_count);
    return rw_count + ro_count;
  endfunction

  function automatic int status_addr(input int rw_count, input int ro_count);
    return rw_count + ro_count + 1;
  endfunction

endpackage

// File: rtl/snax_alu_csr_manager.sv
// Initiator side of the accelerator CSR handshake: stages RW words, serves reads,
// and hands a frozen snapshot of the staged words to the accelerator on launch.
module snax_alu_csr_manager
  import snax_csr_mgr_pkg::*;
#(
  parameter int RegRWCount   = 3,
  parameter int RegROCount   = 2,
  parameter int RegDataWidth = 32,
  parameter int RegAddrWidth = 32
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic [RegAddrWidth-1:0]                  csr_req_addr_i,
  input  logic [RegDataWidth-1:0]                  csr_req_data_i,
  input  logic                                     csr_req_write_i,
  input  logic                                     csr_req_valid_i,
  output logic                                     csr_req_ready_o,
  output logic [RegDataWidth-1:0]                  csr_rsp_data_o,
  output logic                                     csr_rsp_valid_o,
  input  logic                                     csr_rsp_ready_i,
  output logic [RegRWCount-1:0][RegDataWidth-1:0]  csr_reg_set_o,
  output logic                                     csr_reg_set_valid_o,
  input  logic                                     csr_reg_set_ready_i,
  input  logic [RegROCount-1:0][RegDataWidth-1:0]  csr_reg_ro_set_i
);

  localparam logic [RegAddrWidth-1:0] LaunchAddr =
    RegAddrWidth'(launch_addr(RegRWCount, RegROCount));
  localparam logic [RegAddrWidth-1:0] StatusAddr =
    RegAddrWidth'(status_addr(RegRWCount, RegROCount));

  logic [RegRWCount-1:0][RegDataWidth-1:0] staged_q;
  logic [RegRWCount-1:0][RegDataWidth-1:0] snap_q;
  logic [RegDataWidth-1:0]                 rsp_data_q;
  logic [RegDataWidth-1:0]                 rd_data;
  logic                                    rsp_valid_q;
  logic                                    req_fire;
  logic                                    launch_wr;
  logic                                    snap_load;
  launch_state_e                           state_q, state_d;

  // Launch writes are held off while a snapshot is still owned by the accelerator.
  assign launch_wr       = csr_req_write_i & (csr_req_addr_i == LaunchAddr);
  assign csr_req_ready_o = !(rsp_valid_q & !csr_rsp_ready_i) & !(launch_wr & (state_q == LAUNCH));
  assign req_fire        = csr_req_valid_i & csr_req_ready_o;

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < RegRWCount; i++)
      if (csr_req_addr_i == RegAddrWidth'(i)) rd_data = staged_q[i];
    for (int j = 0; j < RegROCount; j++)
      if (csr_req_addr_i == RegAddrWidth'(RegRWCount + j)) rd_data = csr_reg_ro_set_i[j];
    if (csr_req_addr_i == StatusAddr) rd_data[STATUS_PENDING_BIT] = (state_q == LAUNCH);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      staged_q <= '0;
    end else if (req_fire && csr_req_write_i) begin
      for (int i = 0; i < RegRWCount; i++)
        if (csr_req_addr_i == RegAddrWidth'(i)) staged_q[i] <= csr_req_data_i;
    end
  end

  // A new accept wins over consumption so back-to-back reads keep valid high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else if (req_fire && !csr_req_write_i) begin
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= rd_data;
    end else if (csr_rsp_ready_i) begin
      rsp_valid_q <= 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    snap_load = 1'b0;
    case (state_q)
      IDLE: if (req_fire && launch_wr) begin
        state_d   = LAUNCH;
        snap_load = 1'b1;
      end
      LAUNCH: if (csr_reg_set_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      if (snap_load) snap_q <= staged_q;
    end
  end

  assign csr_rsp_valid_o     = rsp_valid_q;
  assign csr_rsp_data_o      = rsp_data_q;
  assign csr_reg_set_o       = snap_q;
  assign csr_reg_set_valid_o = (state_q == LAUNCH);

endmodule

// File: tb/tb_snax_alu_csr_manager.sv
// Bench for snax_alu_csr_manager: vector table, directed multi-cycle sequences, randomized model check.
module tb_snax_alu_csr_manager;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic [31:0]       req_addr, req_data;
  logic              req_write, req_valid, req_ready;
  logic [31:0]       rsp_data;
  logic              rsp_valid, rsp_ready;
  logic [2:0][31:0]  set_o;
  logic              set_valid, set_ready;
  logic [1:0][31:0]  ro_set;

  int checks = 0;
  int failures = 0;

  snax_alu_csr_manager #(
    .RegRWCount(3), .RegROCount(2), .RegDataWidth(32), .RegAddrWidth(32)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .csr_req_addr_i(req_addr), .csr_req_data_i(req_data),
    .csr_req_write_i(req_write), .csr_req_valid_i(req_valid),
    .csr_req_ready_o(req_ready),
    .csr_rsp_data_o(rsp_data), .csr_rsp_valid_o(rsp_valid), .csr_rsp_ready_i(rsp_ready),
    .csr_reg_set_o(set_o), .csr_reg_set_valid_o(set_valid), .csr_reg_set_ready_i(set_ready),
    .csr_reg_ro_set_i(ro_set)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  logic [31:0] m_staged [3];
  logic [31:0] m_snap   [3];
  logic [31:0] m_ro     [2];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Called #1 after a posedge; returns #1 after the accepting posedge.
  task automatic req(input bit wr, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_data = d;
    #1;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) chk("req_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  task automatic read_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    req(1'b0, a, 32'h0);
    chk({nm, "_valid"}, rsp_valid, 1);
    chk(nm, rsp_data, exp);
  endtask

  function automatic logic [95:0] pack3(input logic [31:0] w0, w1, w2);
    return {w2, w1, w0};
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input bit pend);
    if (a < 3)  return m_staged[a];
    if (a == 3) return m_ro[0];
    if (a == 4) return m_ro[1];
    if (a == 6) return {31'b0, pend};
    return 32'h0;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  vec_t vecs[$];

  initial begin
    rst_ni = 1'b0; req_valid = 0; req_write = 0; req_addr = 0; req_data = 0;
    rsp_ready = 1'b1; set_ready = 1'b0;
    ro_set[0] = 32'hCAFE; ro_set[1] = 32'hBEEF;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_set_valid", set_valid, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_set_o", set_o, 0);
    chk("reset_rsp_data", rsp_data, 0);
    rst_ni = 1'b1;
    step();

    vecs.push_back('{1, 32'd0, 32'h11, 0});
    vecs.push_back('{1, 32'd1, 32'h22, 0});
    vecs.push_back('{1, 32'd2, 32'h3, 0});
    vecs.push_back('{0, 32'd0, 0, 32'h11});
    vecs.push_back('{0, 32'd1, 0, 32'h22});
    vecs.push_back('{0, 32'd2, 0, 32'h3});
    vecs.push_back('{0, 32'd3, 0, 32'hCAFE});
    vecs.push_back('{0, 32'd4, 0, 32'hBEEF});
    vecs.push_back('{1, 32'd9, 32'h55, 0});
    vecs.push_back('{0, 32'd9, 0, 32'h0});
    vecs.push_back('{1, 32'd3, 32'h99, 0});
    vecs.push_back('{1, 32'd6, 32'hFFFF, 0});
    vecs.push_back('{0, 32'd3, 0, 32'hCAFE});
    vecs.push_back('{0, 32'd6, 0, 32'h0});
    vecs.push_back('{0, 32'd5, 0, 32'h0});
    vecs.push_back('{0, 32'h0001_0000, 0, 32'h0});
    vecs.push_back('{0, 32'd0, 0, 32'h11});
    vecs.push_back('{0, 32'd1, 0, 32'h22});
    vecs.push_back('{0, 32'd2, 0, 32'h3});
    foreach (vecs[i]) begin
      if (vecs[i].wr) req(1'b1, vecs[i].addr, vecs[i].data);
      else read_chk($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].exp);
    end

    // Launch with accelerator backpressure
    req(1'b1, 32'd5, 32'h1);
    for (int c = 0; c < 3; c++) begin
      chk("launch_valid_held", set_valid, 1);
      chk("launch_set_stable", set_o, pack3(32'h11, 32'h22, 32'h3));
      step();
    end
    read_chk("status_pending", 32'd6, 32'h1);
    req(1'b1, 32'd0, 32'hAA);
    chk("snap_word0_kept", set_o[0], 32'h11);
    read_chk("staged_word0_new", 32'd0, 32'hAA);
    // Second launch stalls through the handshake cycle
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd5; req_data = 32'h0;
    #1;
    for (int c = 0; c < 2; c++) begin
      chk("relaunch_stall", req_ready, 0);
      step();
    end
    set_ready = 1'b1;
    #1;
    chk("relaunch_stall_hs", req_ready, 0);
    chk("hs_valid", set_valid, 1);
    @(posedge clk); #1;
    set_ready = 1'b0;
    chk("valid_drop_after_hs", set_valid, 0);
    chk("relaunch_ready_idle", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0;
    chk("relaunch_valid", set_valid, 1);
    chk("relaunch_word0", set_o[0], 32'hAA);
    chk("relaunch_set", set_o, pack3(32'hAA, 32'h22, 32'h3));
    set_ready = 1'b1;
    step();
    set_ready = 1'b0;
    chk("relaunch_done", set_valid, 0);

    // Response backpressure and back-to-back read
    rsp_ready = 1'b0;
    read_chk("bp_first", 32'd1, 32'h22);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd2;
    #1;
    for (int c = 0; c < 4; c++) begin
      chk("bp_ready_low", req_ready, 0);
      chk("bp_rsp_held_v", rsp_valid, 1);
      chk("bp_rsp_held", rsp_data, 32'h22);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("b2b_ready_comb", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("b2b_rsp_valid", rsp_valid, 1);
    chk("b2b_rsp_data", rsp_data, 32'h3);
    step();
    chk("b2b_rsp_consumed", rsp_valid, 0);

    // Reset while a launch is pending
    req(1'b1, 32'd5, 32'h0);
    chk("prerst_valid", set_valid, 1);
    rst_ni = 1'b0;
    #1;
    chk("rst_drops_valid", set_valid, 0);
    chk("rst_clears_snap", set_o, 0);
    step();
    rst_ni = 1'b1;
    step();
    read_chk("postrst_addr0", 32'd0, 32'h0);
    read_chk("postrst_status", 32'd6, 32'h0);

    // Randomized phase against the model
    for (int i = 0; i < 3; i++) begin m_staged[i] = '0; m_snap[i] = '0; end
    for (int it = 0; it < 150; it++) begin
      int op;
      logic [31:0] a, d;
      op = $urandom_range(0, 9);
      for (int j = 0; j < 2; j++) begin m_ro[j] = $urandom; ro_set[j] = m_ro[j]; end
      if (op < 4) begin
        a = $urandom_range(0, 10);
        if (a == 5) a = 32'hFFFF_FFFF;
        d = $urandom;
        req(1'b1, a, d);
        if (a < 3) m_staged[a] = d;
      end else if (op < 8) begin
        a = $urandom_range(0, 10);
        read_chk("rnd_read", a, model_read(a, 1'b0));
      end else begin
        int k;
        req(1'b1, 32'd5, $urandom);
        for (int i = 0; i < 3; i++) m_snap[i] = m_staged[i];
        chk("rnd_launch_valid", set_valid, 1);
        chk("rnd_launch_set", set_o, pack3(m_snap[0], m_snap[1], m_snap[2]));
        k = $urandom_range(0, 3);
        for (int c = 0; c < k; c++) begin
          case ($urandom_range(0, 2))
            0: begin
              a = $urandom_range(0, 2); d = $urandom;
              req(1'b1, a, d);
              m_staged[a] = d;
            end
            1: read_chk("rnd_status", 32'd6, model_read(32'd6, 1'b1));
            default: step();
          endcase
          chk("rnd_hold_valid", set_valid, 1);
          chk("rnd_hold_set", set_o, pack3(m_snap[0], m_snap[1], m_snap[2]));
        end
        set_ready = 1'b1;
        step();
        set_ready = 1'b0;
        chk("rnd_hs_drop", set_valid, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
